// File: rtl/sa_sched_pkg.sv
// Shared types for the systolic-array tile scheduler: one-hot state encoding
// and the default drain length.
package sa_sched_pkg;

    localparam int TILE_W_DEFAULT = 8;

    typedef enum logic [6:0] {
        S_IDLE  = 7'b000_0001,
        S_LOAD  = 7'b000_0010,
        S_START = 7'b000_0100,
        S_FEED  = 7'b000_1000,
        S_DRAIN = 7'b001_0000,
        S_OUT   = 7'b010_0000,
        S_DONE  = 7'b100_0000
    } state_t;

    // Shift cycles for the last operand wavefront to cross an X_R x W_C array.
    function automatic int drain_cyc_f(input int x_r, input int w_c);
        return x_r + w_c - 1;
    endfunction

endpackage

// File: rtl/sa_tile_counter.sv
// Nested r/c/k tile index counters (k innermost, r outermost) with last-tile
// flags compared against the latched minus-one tile counts.
module sa_tile_counter
    import sa_sched_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TILE_W-1:0] r_tiles,
    input  logic [TILE_W-1:0] c_tiles,
    input  logic [TILE_W-1:0] k_tiles,
    input  logic              k_adv,
    input  logic              tile_adv,
    output logic [TILE_W-1:0] r_idx,
    output logic [TILE_W-1:0] c_idx,
    output logic [TILE_W-1:0] k_idx,
    output logic              k_last,
    output logic              tile_last
);

    logic [TILE_W-1:0] r_max_q, r_max_d, c_max_q, c_max_d, k_max_q, k_max_d;
    logic [TILE_W-1:0] r_q, r_d, c_q, c_d, k_q, k_d;
    logic              r_last, c_last;

    assign r_last    = (r_q == r_max_q);
    assign c_last    = (c_q == c_max_q);
    assign k_last    = (k_q == k_max_q);
    assign tile_last = r_last && c_last;

    always_comb begin
        r_max_d = r_max_q;
        c_max_d = c_max_q;
        k_max_d = k_max_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        if (load) begin
            r_max_d = r_tiles;
            c_max_d = c_tiles;
            k_max_d = k_tiles;
            r_d     = '0;
            c_d     = '0;
            k_d     = '0;
        end else if (k_adv) begin
            k_d = k_q + TILE_W'(1);
        end else if (tile_adv) begin
            // Finishing the last tile wraps everything to zero, ready for a new job.
            k_d = '0;
            if (c_last) begin
                c_d = '0;
                r_d = r_last ? '0 : r_q + TILE_W'(1);
            end else begin
                c_d = c_q + TILE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max_q <= '0;
            c_max_q <= '0;
            k_max_q <= '0;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
        end else begin
            r_max_q <= r_max_d;
            c_max_q <= c_max_d;
            k_max_q <= k_max_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
        end
    end

    assign r_idx = r_q;
    assign c_idx = c_q;
    assign k_idx = k_q;

endmodule

// File: rtl/sa_tile_scheduler.sv
// Tile sequencer for the systolic-array feeder: load operands, start/feed each
// depth tile, drain the array, then hand the output tile to the result writer.
module sa_tile_scheduler
    import sa_sched_pkg::*;
#(
    parameter int M_DIM     = 16,
    parameter int X_R       = 16,
    parameter int W_C       = 16,
    parameter int TILE_W    = TILE_W_DEFAULT,
    parameter int DRAIN_CYC = drain_cyc_f(X_R, W_C)
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic              I_JOB_VALID,
    output logic              O_JOB_READY,
    input  logic [TILE_W-1:0] I_R_TILES,
    input  logic [TILE_W-1:0] I_C_TILES,
    input  logic [TILE_W-1:0] I_K_TILES,
    output logic              O_LD_REQ,
    output logic [TILE_W-1:0] O_LD_R_IDX,
    output logic [TILE_W-1:0] O_LD_C_IDX,
    output logic [TILE_W-1:0] O_LD_K_IDX,
    input  logic              I_LD_ACK,
    output logic              O_SA_START,
    output logic              O_SA_PE_SHIFT,
    output logic              O_SA_SYNC_RSTN,
    input  logic              I_SA_OVER,
    output logic              O_ACC_CLR,
    input  logic              I_STALL,
    output logic              O_RES_VALID,
    input  logic              I_RES_READY,
    output logic [TILE_W-1:0] O_RES_R_IDX,
    output logic [TILE_W-1:0] O_RES_C_IDX,
    output logic              O_BUSY,
    output logic              O_JOB_DONE
);

    localparam int DW = $clog2(DRAIN_CYC + 1);

    if (M_DIM < 1 || DRAIN_CYC < 1) begin : g_bad_params
        $error("sa_tile_scheduler: M_DIM and DRAIN_CYC must be at least 1");
    end

    state_t            state_q, state_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              run, shift, cnt_load, k_adv, tile_adv, k_last, tile_last;
    logic              ld_req, res_valid;
    logic [TILE_W-1:0] r_idx, c_idx, k_idx;

    sa_tile_counter #(.TILE_W(TILE_W)) u_cnt (
        .clk       (I_CLK),
        .rst       (I_RST),
        .load      (cnt_load),
        .r_tiles   (I_R_TILES),
        .c_tiles   (I_C_TILES),
        .k_tiles   (I_K_TILES),
        .k_adv     (k_adv),
        .tile_adv  (tile_adv),
        .r_idx     (r_idx),
        .c_idx     (c_idx),
        .k_idx     (k_idx),
        .k_last    (k_last),
        .tile_last (tile_last)
    );

    // All handshakes (job, load, result): a transfer happens on a rising edge
    // where valid/req and ready/ack are both high; the requester holds until then.
    assign run   = !I_RST;
    assign shift = run && (state_q == S_FEED || state_q == S_DRAIN) && !I_STALL;

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        cnt_load = 1'b0;
        k_adv    = 1'b0;
        tile_adv = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (I_JOB_VALID) begin
                    cnt_load = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD:  if (I_LD_ACK) state_d = S_START;
            S_START: state_d = S_FEED;
            S_FEED: begin
                // The feeder only returns to idle once its over flag is shifted out.
                if (I_SA_OVER && shift) begin
                    if (k_last) begin
                        drain_d = DW'(DRAIN_CYC);
                        state_d = S_DRAIN;
                    end else begin
                        k_adv   = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (shift) begin
                    drain_d = drain_q - DW'(1);
                    if (drain_q == DW'(1)) state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (I_RES_READY) begin
                    tile_adv = 1'b1;
                    state_d  = tile_last ? S_DONE : S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q <= S_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    assign ld_req         = run && (state_q == S_LOAD);
    assign res_valid      = run && (state_q == S_OUT);
    assign O_JOB_READY    = run && (state_q == S_IDLE);
    assign O_LD_REQ       = ld_req;
    assign O_LD_R_IDX     = ld_req ? r_idx : '0;
    assign O_LD_C_IDX     = ld_req ? c_idx : '0;
    assign O_LD_K_IDX     = ld_req ? k_idx : '0;
    assign O_SA_START     = run && (state_q == S_START);
    assign O_ACC_CLR      = run && (state_q == S_START) && (k_idx == '0);
    assign O_SA_PE_SHIFT  = shift;
    assign O_SA_SYNC_RSTN = !I_RST;
    assign O_RES_VALID    = res_valid;
    assign O_RES_R_IDX    = res_valid ? r_idx : '0;
    assign O_RES_C_IDX    = res_valid ? c_idx : '0;
    assign O_BUSY         = run && (state_q != S_IDLE);
    assign O_JOB_DONE     = run && (state_q == S_DONE);

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Bench for sa_tile_scheduler: a job-level model expands each job into a
// per-cycle list of inputs and expected outputs, replayed against the DUT.
module tb_sa_tile_scheduler;

    localparam int M  = 4;
    localparam int XR = 4;
    localparam int WC = 4;
    localparam int TW = 8;
    localparam int D  = XR + WC - 1;

    logic          clk = 1'b0;
    logic          I_RST = 1'b1, I_JOB_VALID = 1'b0, I_LD_ACK = 1'b0;
    logic          I_SA_OVER = 1'b0, I_STALL = 1'b0, I_RES_READY = 1'b0;
    logic [TW-1:0] I_R_TILES = '0, I_C_TILES = '0, I_K_TILES = '0;
    logic          O_JOB_READY, O_LD_REQ, O_SA_START, O_SA_PE_SHIFT, O_SA_SYNC_RSTN;
    logic          O_ACC_CLR, O_RES_VALID, O_BUSY, O_JOB_DONE;
    logic [TW-1:0] O_LD_R_IDX, O_LD_C_IDX, O_LD_K_IDX, O_RES_R_IDX, O_RES_C_IDX;

    always #5 clk = ~clk;

    sa_tile_scheduler #(.M_DIM(M), .X_R(XR), .W_C(WC), .TILE_W(TW)) dut (
        .I_CLK(clk), .I_RST(I_RST), .I_JOB_VALID(I_JOB_VALID), .O_JOB_READY(O_JOB_READY),
        .I_R_TILES(I_R_TILES), .I_C_TILES(I_C_TILES), .I_K_TILES(I_K_TILES),
        .O_LD_REQ(O_LD_REQ), .O_LD_R_IDX(O_LD_R_IDX), .O_LD_C_IDX(O_LD_C_IDX),
        .O_LD_K_IDX(O_LD_K_IDX), .I_LD_ACK(I_LD_ACK), .O_SA_START(O_SA_START),
        .O_SA_PE_SHIFT(O_SA_PE_SHIFT), .O_SA_SYNC_RSTN(O_SA_SYNC_RSTN),
        .I_SA_OVER(I_SA_OVER), .O_ACC_CLR(O_ACC_CLR), .I_STALL(I_STALL),
        .O_RES_VALID(O_RES_VALID), .I_RES_READY(I_RES_READY),
        .O_RES_R_IDX(O_RES_R_IDX), .O_RES_C_IDX(O_RES_C_IDX),
        .O_BUSY(O_BUSY), .O_JOB_DONE(O_JOB_DONE)
    );

    typedef struct packed {
        logic          rst, job_valid;
        logic [TW-1:0] r_t, c_t, k_t;
        logic          ld_ack, sa_over, stall, res_ready;
    } in_t;

    typedef struct packed {
        logic          job_ready, ld_req;
        logic [TW-1:0] ld_r, ld_c, ld_k;
        logic          sa_start, pe_shift, sync_rstn, acc_clr, res_valid;
        logic [TW-1:0] res_r, res_c;
        logic          busy, job_done;
    } obs_t;

    in_t  in_q[$];
    obs_t exp_q[$];
    int   offs_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic obs_t obs_busy();
        obs_t o = '0;
        o.sync_rstn = 1'b1;
        o.busy      = 1'b1;
        return o;
    endfunction

    // Random values on inputs the DUT must ignore in the current phase.
    function automatic in_t noise(input bit spur);
        in_t n = '0;
        if (spur) begin
            n.job_valid = 1'($urandom_range(0, 1));
            n.r_t       = TW'($urandom_range(0, 255));
            n.c_t       = TW'($urandom_range(0, 255));
            n.k_t       = TW'($urandom_range(0, 255));
            n.ld_ack    = 1'($urandom_range(0, 1));
            n.sa_over   = 1'($urandom_range(0, 1));
            n.stall     = 1'($urandom_range(0, 1));
            n.res_ready = 1'($urandom_range(0, 1));
        end
        return n;
    endfunction

    task automatic push(input in_t i, input obs_t o);
        in_q.push_back(i);
        exp_q.push_back(o);
    endtask

    task automatic push_reset(input int n);
        in_t i = '0;
        i.rst = 1'b1;
        for (int j = 0; j < n; j++) push(i, obs_t'(0));
    endtask

    task automatic push_idle(input int n);
        obs_t o = '0;
        o.job_ready = 1'b1;
        o.sync_rstn = 1'b1;
        for (int j = 0; j < n; j++) push(in_t'(0), o);
    endtask

    // ack_d/rdy_d < 0 pick random waits; stall_mode 0 none, 1 random, 2 fixed 3+2.
    task automatic gen_job(input int rt, input int ct, input int kt, input int ack_d,
                           input int rdy_d, input int stall_mode, input bit spur,
                           input int abort_blk);
        int   extra, blk, ad, rd, sh, nst;
        in_t  i;
        obs_t o;
        extra = 0;
        blk   = 0;
        i = '0;
        i.job_valid = 1'b1;
        i.r_t = TW'(rt);
        i.c_t = TW'(ct);
        i.k_t = TW'(kt);
        o = '0;
        o.job_ready = 1'b1;
        o.sync_rstn = 1'b1;
        push(i, o);
        for (int r = 0; r <= rt; r++) begin
            for (int c = 0; c <= ct; c++) begin
                for (int k = 0; k <= kt; k++) begin
                    ad = (ack_d < 0) ? int'($urandom_range(0, 3)) : ack_d;
                    extra += ad;
                    for (int w = 0; w <= ad; w++) begin
                        i = noise(spur);
                        i.ld_ack = (w == ad);
                        o = obs_busy();
                        o.ld_req = 1'b1;
                        o.ld_r = TW'(r);
                        o.ld_c = TW'(c);
                        o.ld_k = TW'(k);
                        push(i, o);
                    end
                    i = noise(spur);
                    o = obs_busy();
                    o.sa_start = 1'b1;
                    o.acc_clr  = (k == 0);
                    push(i, o);
                    sh  = 0;
                    nst = 0;
                    while (sh <= M) begin
                        if (blk == abort_blk && sh == 2) return;
                        i = noise(spur);
                        i.sa_over = (sh == M);
                        i.stall = (stall_mode == 1) ? ($urandom_range(0, 3) == 0) :
                                  (stall_mode == 2 && sh == 2 && nst < 3);
                        o = obs_busy();
                        o.pe_shift = !i.stall;
                        push(i, o);
                        if (i.stall) begin
                            extra++;
                            nst++;
                        end else begin
                            sh++;
                        end
                    end
                    blk++;
                end
                sh  = 0;
                nst = 0;
                while (sh < D) begin
                    i = noise(spur);
                    i.stall = (stall_mode == 1) ? ($urandom_range(0, 3) == 0) :
                              (stall_mode == 2 && sh == 3 && nst < 2);
                    o = obs_busy();
                    o.pe_shift = !i.stall;
                    push(i, o);
                    if (i.stall) begin
                        extra++;
                        nst++;
                    end else begin
                        sh++;
                    end
                end
                rd = (rdy_d < 0) ? int'($urandom_range(0, 3)) : rdy_d;
                extra += rd;
                for (int w = 0; w <= rd; w++) begin
                    i = noise(spur);
                    i.res_ready = (w == rd);
                    o = obs_busy();
                    o.res_valid = 1'b1;
                    o.res_r = TW'(r);
                    o.res_c = TW'(c);
                    push(i, o);
                end
            end
        end
        i = noise(spur);
        o = obs_busy();
        o.job_done = 1'b1;
        push(i, o);
        offs_q.push_back(1 + (rt + 1) * (ct + 1) * ((kt + 1) * (M + 3) + D + 1) + extra);
    endtask

    in_t  cur;
    obs_t exp_o, ob;
    int   cyc = 0, acc_cyc = 0, eo;
    bit   acc_valid = 1'b0;

    initial begin
        push_reset(2);
        push_idle(2);
        gen_job(0, 0, 0, 0, 0, 0, 1'b0, -1);
        push_idle(1);
        gen_job(1, 1, 2, 0, 0, 0, 1'b0, -1);
        gen_job(0, 0, 0, 0, 0, 2, 1'b0, -1);
        gen_job(0, 0, 0, 4, 6, 0, 1'b0, -1);
        gen_job(1, 1, 1, 0, 0, 0, 1'b0, 1);
        push_reset(1);
        gen_job(0, 0, 0, 0, 0, 0, 1'b0, -1);
        gen_job(0, 0, 0, 0, 0, 0, 1'b1, -1);
        for (int j = 0; j < 6; j++) begin
            push_idle($urandom_range(0, 2));
            gen_job($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                    -1, -1, 1, 1'b1, -1);
        end
        push_idle(2);

        while (in_q.size() > 0) begin
            cur   = in_q.pop_front();
            exp_o = exp_q.pop_front();
            @(posedge clk);
            #1;
            I_RST       = cur.rst;
            I_JOB_VALID = cur.job_valid;
            I_R_TILES   = cur.r_t;
            I_C_TILES   = cur.c_t;
            I_K_TILES   = cur.k_t;
            I_LD_ACK    = cur.ld_ack;
            I_SA_OVER   = cur.sa_over;
            I_STALL     = cur.stall;
            I_RES_READY = cur.res_ready;
            #3;
            ob.job_ready = O_JOB_READY;
            ob.ld_req    = O_LD_REQ;
            ob.ld_r      = O_LD_R_IDX;
            ob.ld_c      = O_LD_C_IDX;
            ob.ld_k      = O_LD_K_IDX;
            ob.sa_start  = O_SA_START;
            ob.pe_shift  = O_SA_PE_SHIFT;
            ob.sync_rstn = O_SA_SYNC_RSTN;
            ob.acc_clr   = O_ACC_CLR;
            ob.res_valid = O_RES_VALID;
            ob.res_r     = O_RES_R_IDX;
            ob.res_c     = O_RES_C_IDX;
            ob.busy      = O_BUSY;
            ob.job_done  = O_JOB_DONE;
            checks++;
            assert (ob === exp_o) else begin
                errors++;
                $error("FAIL outputs cyc=%0d observed=%h expected=%h", cyc, ob, exp_o);
            end
            if (cur.rst) begin
                acc_valid = 1'b0;
            end else if (cur.job_valid && ob.job_ready) begin
                acc_valid = 1'b1;
                acc_cyc   = cyc;
            end
            if (ob.job_done) begin
                eo = (offs_q.size() > 0) ? offs_q.pop_front() : -1;
                checks++;
                assert (acc_valid && (cyc - acc_cyc) === eo) else begin
                    errors++;
                    $error("FAIL done_latency cyc=%0d observed=%0d expected=%0d",
                           cyc, acc_valid ? cyc - acc_cyc : -1, eo);
                end
                acc_valid = 1'b0;
            end
            cyc++;
        end

        checks++;
        assert (offs_q.size() === 0) else begin
            errors++;
            $error("FAIL missing_done observed=%0d expected=0", offs_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
